// File: rtl/digit_serial_adder.sv
// Multi-cycle adder: A + B + Ci, one DIGIT-bit slice per clock, LSB first.
// Results (S, Co, OV) are registered and only move on the edge that enters DONE.
module digit_serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             OV
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] sum_next;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic [DIGIT-1:0] a_digit;
  logic [DIGIT-1:0] b_digit;
  logic [DIGIT:0]   slice_sum;
  logic             last_digit;
  logic             ov_next;

  always_comb begin
    a_digit = '0;
    b_digit = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_reg == CW'(i)) begin
        a_digit = a_reg[i*DIGIT +: DIGIT];
        b_digit = b_reg[i*DIGIT +: DIGIT];
      end
    end
  end

  assign slice_sum  = {1'b0, a_digit} + {1'b0, b_digit} + {{DIGIT{1'b0}}, carry_reg};
  assign last_digit = (cnt_reg == CW'(N - 1));

  // Merge the current slice into the partial sum so the final edge can publish the full word.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_sum_slice
      assign sum_next[gi*DIGIT +: DIGIT] = (cnt_reg == CW'(gi)) ? slice_sum[DIGIT-1:0]
                                                                : sum_reg[gi*DIGIT +: DIGIT];
    end
  endgenerate

  // Carry into the MSB is recovered as a ^ b ^ s at that bit position.
  assign ov_next = a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ sum_next[WIDTH-1] ^ slice_sum[DIGIT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      S         <= '0;
      Co        <= 1'b0;
      OV        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg     <= A;
            b_reg     <= B;
            carry_reg <= Ci;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= RUN;
          end else begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        RUN: begin
          sum_reg   <= sum_next;
          carry_reg <= slice_sum[DIGIT];
          cnt_reg   <= cnt_reg + CW'(1);
          if (last_digit) begin
            S         <= sum_next;
            Co        <= slice_sum[DIGIT];
            OV        <= ov_next;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
